// File: rtl/tl_dp.sv
// Traffic-light datapath: phase counter, green/blink pass index, phase-end flags
// and registered lamp drivers for the one-hot light-sequence controller.
module tl_dp #(
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned G1_CYC    = 1024,
  parameter int unsigned BLINK_CYC = 32,
  parameter int unsigned NONE_CYC  = 32,
  parameter int unsigned Y_CYC     = 512,
  parameter int unsigned R_CYC     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       curr_state,
  input  logic             dp_cnt_rst,
  output logic [6:0]       done_state,
  output logic             light_g,
  output logic             light_y,
  output logic             light_r,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam int unsigned D_G1    = 0;
  localparam int unsigned D_G2    = 1;
  localparam int unsigned D_G3    = 2;
  localparam int unsigned D_Y     = 3;
  localparam int unsigned D_R     = 4;
  localparam int unsigned D_NONE1 = 5;
  localparam int unsigned D_NONE2 = 6;

  localparam logic [CNT_W-1:0] G1_LAST    = CNT_W'(G1_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);
  localparam logic [CNT_W-1:0] NONE_LAST  = CNT_W'(NONE_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] R_LAST     = CNT_W'(R_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_g_idx;
  logic             r_light_g;
  logic             r_light_y;
  logic             r_light_r;
  logic             r_err;

  logic             w_active;
  logic             w_onehot;
  logic             w_multi;
  logic             w_gi0;
  logic [6:0]       w_done;

  assign w_active = (curr_state != 4'd0);
  assign w_onehot = w_active && ((curr_state & (curr_state - 4'd1)) == 4'd0);
  assign w_multi  = w_active && !w_onehot;
  // An illegal pass index of 3 is decoded as the start of the green sequence.
  assign w_gi0    = (r_g_idx == 2'd0) || (r_g_idx == 2'd3);

  // Phase-end decode; silent during reset, idle or multi-hot state.
  always_comb begin
    w_done = 7'd0;
    if (!rst && w_onehot) begin
      if (curr_state[0]) begin
        if (w_gi0 && (r_cnt == G1_LAST))
          w_done[D_G1] = 1'b1;
        else if ((r_g_idx == 2'd1) && (r_cnt == BLINK_LAST))
          w_done[D_G2] = 1'b1;
        else if ((r_g_idx == 2'd2) && (r_cnt == BLINK_LAST))
          w_done[D_G3] = 1'b1;
      end
      if (curr_state[1] && (r_cnt == Y_LAST))
        w_done[D_Y] = 1'b1;
      if (curr_state[2] && (r_cnt == R_LAST))
        w_done[D_R] = 1'b1;
      if (curr_state[3]) begin
        if ((r_g_idx == 2'd1) && (r_cnt == NONE_LAST))
          w_done[D_NONE1] = 1'b1;
        else if ((r_g_idx == 2'd2) && (r_cnt == NONE_LAST))
          w_done[D_NONE2] = 1'b1;
      end
    end
  end

  // Phase counter: cleared by the controller strobe, frozen while idle.
  always_ff @(posedge clk) begin
    if (rst || dp_cnt_rst)
      r_cnt <= '0;
    else if (w_active)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  // Green/blink pass index.
  always_ff @(posedge clk) begin
    if (rst)
      r_g_idx <= 2'd0;
    else if (w_done[D_G1])
      r_g_idx <= 2'd1;
    else if (w_done[D_G2])
      r_g_idx <= 2'd2;
    else if (w_done[D_G3])
      r_g_idx <= 2'd0;
  end

  // Lamps follow the state one cycle later, dark unless the state is one-hot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_light_g <= 1'b0;
      r_light_y <= 1'b0;
      r_light_r <= 1'b0;
    end else begin
      r_light_g <= w_onehot && curr_state[0];
      r_light_y <= w_onehot && curr_state[1];
      r_light_r <= w_onehot && curr_state[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_multi)
      r_err <= 1'b1;
  end

  assign done_state = w_done;
  assign cnt        = r_cnt;
  assign light_g    = r_light_g;
  assign light_y    = r_light_y;
  assign light_r    = r_light_r;
  assign err        = r_err;

endmodule

// File: tb/tb_tl_dp.sv
// Directed bench for tl_dp with a small behavioural light-sequence controller.
module tb_tl_dp;

  localparam int unsigned CNT_W = 5;

  logic             clk;
  logic             rst;
  logic [3:0]       curr_state;
  logic             dp_cnt_rst;
  logic [6:0]       done_state;
  logic             light_g;
  logic             light_y;
  logic             light_r;
  logic [CNT_W-1:0] cnt;
  logic             err;

  int n_chk;
  int n_err;

  // Expected phase table for the full loop G1 NONE1 G2 NONE2 G3 Y R.
  int unsigned ph_st  [7] = '{1, 8, 1, 8, 1, 2, 4};
  int unsigned ph_len [7] = '{8, 2, 2, 2, 2, 4, 6};
  int unsigned ph_bit [7] = '{0, 5, 1, 6, 2, 3, 4};
  int unsigned ph;
  int unsigned pos;
  logic [2:0]  exp_l;
  int          greens;
  int          fires;

  tl_dp #(
    .CNT_W(CNT_W), .G1_CYC(8), .BLINK_CYC(2), .NONE_CYC(2), .Y_CYC(4), .R_CYC(6)
  ) dut (
    .clk(clk), .rst(rst), .curr_state(curr_state), .dp_cnt_rst(dp_cnt_rst),
    .done_state(done_state), .light_g(light_g), .light_y(light_y),
    .light_r(light_r), .cnt(cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change #1 after the edge, sampling #2 after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] st);
    rst        = 1'b1;
    curr_state = st;
    dp_cnt_rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    ph    = 0;
    pos   = 0;
    exp_l = 3'd0;
  endtask

  function automatic logic [3:0] ctl_next(input logic [3:0] cs, input logic [6:0] d);
    if (d[0] || d[1]) return 4'b1000;
    if (d[5] || d[6] || d[4]) return 4'b0001;
    if (d[2]) return 4'b0010;
    if (d[3]) return 4'b0100;
    return cs;
  endfunction

  // Controller closes the loop each cycle; the phase table predicts outputs.
  task automatic run_loop(input int n);
    logic [3:0] ns;
    for (int i = 0; i < n; i++) begin
      check("loop_done", 32'(done_state), (pos == ph_len[ph] - 1) ? (32'd1 << ph_bit[ph]) : 32'd0);
      check("loop_cnt", 32'(cnt), 32'(pos));
      check("loop_lamps", {29'd0, light_r, light_y, light_g}, {29'd0, exp_l});
      greens += int'(light_g);
      if (done_state != 7'd0) fires++;
      ns         = ctl_next(curr_state, done_state);
      dp_cnt_rst = |done_state;
      exp_l      = 3'(ph_st[ph]);
      pos++;
      if (pos == ph_len[ph]) begin
        pos = 0;
        ph  = (ph + 1) % 7;
      end
      @(posedge clk);
      #1;
      curr_state = ns;
      dp_cnt_rst = 1'b0;
      #1;
    end
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    greens     = 0;
    fires      = 0;
    clk        = 1'b0;
    rst        = 1'b1;
    curr_state = 4'b0001;
    dp_cnt_rst = 1'b0;

    // Outputs during reset with S_G applied.
    step();
    check("rst_done", 32'(done_state), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_lamps", {29'd0, light_r, light_y, light_g}, 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Two full periods of the closed loop.
    do_reset(4'b0001);
    run_loop(52);
    check("period_state", 32'(curr_state), 32'd1);
    check("period_cnt", 32'(cnt), 32'd0);
    check("green_cycles", 32'(greens), 32'd24);
    check("done_fires", 32'(fires), 32'd14);

    // Multi-hot state on the cycle where DONE_G1 would otherwise fire.
    do_reset(4'b0001);
    repeat (7) step();
    check("pre_multi_done", 32'(done_state), 32'd1);
    curr_state = 4'b0011;
    #1;
    check("multi_done", 32'(done_state), 32'd0);
    check("multi_err_pre", 32'(err), 32'd0);
    @(posedge clk);
    #1 curr_state = 4'b0100;
    #1;
    check("multi_err", 32'(err), 32'd1);
    check("multi_cnt", 32'(cnt), 32'd8);
    check("multi_lamps", {29'd0, light_r, light_y, light_g}, 32'd0);
    repeat (3) step();
    check("sticky_err", 32'(err), 32'd1);
    check("legal_light_r", {29'd0, light_r, light_y, light_g}, 32'd4);
    check("legal_cnt", 32'(cnt), 32'd11);
    // Idle state: counter frozen, all quiet.
    curr_state = 4'b0000;
    repeat (2) step();
    check("idle_cnt", 32'(cnt), 32'd11);
    check("idle_done", 32'(done_state), 32'd0);
    check("idle_lamps", {29'd0, light_r, light_y, light_g}, 32'd0);
    check("idle_err", 32'(err), 32'd1);
    do_reset(4'b0000);
    check("err_cleared", 32'(err), 32'd0);

    // Yellow held with no counter strobe: fires at 3, wraps at 32, fires again.
    do_reset(4'b0010);
    fires = 0;
    for (int i = 0; i < 40; i++) begin
      check("yhold_cnt", 32'(cnt), 32'(i % 32));
      check("yhold_done", 32'(done_state), ((i % 32) == 3) ? 32'd8 : 32'd0);
      if (done_state != 7'd0) fires++;
      step();
    end
    check("yhold_fires", 32'(fires), 32'd2);

    // Reset at cnt=1 of NONE2, then resume green from the first pass.
    do_reset(4'b0001);
    run_loop(13);
    check("none2_state", 32'(curr_state), 32'd8);
    check("none2_cnt", 32'(cnt), 32'd1);
    rst        = 1'b1;
    curr_state = 4'b0001;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_cnt", 32'(cnt), 32'd0);
    check("midrst_lamps", {29'd0, light_r, light_y, light_g}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("resume_done", 32'(done_state), (i == 7) ? 32'd1 : 32'd0);
      check("resume_cnt", 32'(cnt), 32'(i));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tl_dp.md
# tl_dp

Traffic-light datapath paired with the one-hot light-sequence controller. It consumes the controller's current state and counter-reset strobe and produces the `done_state` vector that drives the controller's transitions. Internally it holds the phase duration counter and the green-blink pass index. It also drives the registered lamp outputs.

## Interface
Parameters:
- CNT_W, 11: phase counter width; every *_CYC must be ≤ 2^CNT_W.
- G1_CYC, 1024: cycles of the main green phase G1.
- BLINK_CYC, 32: cycles of each blink-on green phase, G2 and G3.
- NONE_CYC, 32: cycles of each dark phase, NONE1 and NONE2.
- Y_CYC, 512: cycles of yellow.
- R_CYC, 1024: cycles of red.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- curr_state  in  4  one-hot controller state; bit0 S_G, bit1 S_Y, bit2 S_R, bit3 S_NONE.
- dp_cnt_rst  in  1  controller strobe; clears the phase counter at the next edge.
- done_state  out  7  combinational phase-end flags; bit0 DONE_G1, bit1 DONE_G2, bit2 DONE_G3, bit3 DONE_Y, bit4 DONE_R, bit5 DONE_NONE1, bit6 DONE_NONE2.
- light_g  out  1  green lamp, registered.
- light_y  out  1  yellow lamp, registered.
- light_r  out  1  red lamp, registered.
- cnt  out  CNT_W  current phase counter value, for debug and verification.
- err  out  1  sticky flag: curr_state was multi-hot.

## Operation
- Phase counter `cnt`:
  - rst or dp_cnt_rst: cnt <= 0.
  - curr_state == 0: cnt holds at its current value.
  - Otherwise: cnt <= cnt + 1, wrapping modulo 2^CNT_W. Wrap never occurs in legal operation.
- Pass index `g_idx` (2 bits) tracks position in the green/blink sequence. Reset value 0.
  - g_idx <= g_idx + 1 on DONE_G1 or DONE_G2.
  - g_idx <= 0 on DONE_G3.
  - g_idx holds otherwise.
  - Value 3 is illegal; if reached, it behaves as 0 on the next S_G end.
- done_state is combinational. At most one bit is set. A bit is set only when cnt == LEN-1 with:
  - DONE_G1: S_G and g_idx == 0, LEN = G1_CYC.
  - DONE_G2: S_G and g_idx == 1, LEN = BLINK_CYC.
  - DONE_G3: S_G and g_idx == 2, LEN = BLINK_CYC.
  - DONE_NONE1: S_NONE and g_idx == 1, LEN = NONE_CYC.
  - DONE_NONE2: S_NONE and g_idx == 2, LEN = NONE_CYC.
  - DONE_Y: S_Y, LEN = Y_CYC.
  - DONE_R: S_R, LEN = R_CYC.
- Resulting sequence: G1 → NONE1 → G2 → NONE2 → G3 → Y → R → G1.
- Lamps, registered: light_g <= curr_state[0], light_y <= curr_state[1], light_r <= curr_state[2]. All three lamps are 0 in S_NONE.
- Multi-hot curr_state:
  - done_state is forced to 0.
  - Lamps are forced to 0.
  - err is set and holds until rst.
  - Counter keeps counting.
- curr_state == 0: done_state = 0, lamps = 0, err unaffected.

## Timing
- Reset values: cnt 0, g_idx 0, light_g/y/r 0, err 0. done_state is 0 during rst regardless of curr_state.
- Handshake with the controller:
  - done bit rises in the cycle where cnt == LEN-1.
  - Controller answers with dp_cnt_rst in the same cycle.
  - At the next edge, the state changes and cnt = 0.
  - Each phase therefore occupies exactly LEN cycles.
- If dp_cnt_rst is not returned, cnt advances past LEN-1 and the done bit drops. No re-fire occurs until wrap.
- dp_cnt_rst asserted mid-phase (no done) restarts that phase; g_idx is unchanged.
- Lamp latency: 1 cycle after curr_state.
- rst mid-phase: everything returns to reset values at that edge; g_idx restarts at 0.
- dp_cnt_rst and rst together: identical to rst.

## Test plan
Use CNT_W=5, G1_CYC=8, BLINK_CYC=2, NONE_CYC=2, Y_CYC=4, R_CYC=6, driven by a behavioural controller model.
- Release rst with curr_state=S_G held → DONE_G1 high exactly on the 8th cycle (cnt=7); all outputs 0 during rst.
- Full loop from reset → done order G1, NONE1, G2, NONE2, G3, Y, R; phase lengths 8, 2, 2, 2, 2, 4, 6; period 26 cycles; g_idx back to 0 after G3.
- Lamps → light_g high for 8+2+2 = 12 state-cycles per period, each lagging curr_state by 1 cycle; all lamps dark in NONE phases.
- Hold S_Y with dp_cnt_rst suppressed → DONE_Y high only at cnt=3; cnt reaches 31 and wraps to 0; DONE_Y re-fires at cnt=3 of the wrap.
- Drive curr_state=4'b0011 for 1 cycle → err=1, sticky through later legal states until rst; done_state=0 in that cycle.
- Assert rst at cnt=1 of NONE2 → next cycle cnt=0, g_idx=0, lamps 0; resuming S_G yields DONE_G1 after 8 cycles.
